// File: rtl/io_sram_if.sv
// IO bus between the system-bus initiator and a responder target.
// The initiator holds io_read/io_write until it sees an io_ready pulse.
interface io_sram_if;
  logic [31:0] io_addr;
  logic        io_read;
  logic        io_write;
  logic [31:0] io_wdata;
  logic [1:0]  io_byte_size;
  logic        burst;
  logic [2:0]  burst_size;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic        io_err;
  logic [7:0]  err_count;

  modport master (
    output io_addr, io_read, io_write, io_wdata, io_byte_size, burst, burst_size,
    input  io_rdata, io_ready, io_err, err_count
  );

  modport slave (
    input  io_addr, io_read, io_write, io_wdata, io_byte_size, burst, burst_size,
    output io_rdata, io_ready, io_err, err_count
  );
endinterface

// File: rtl/io_sram_responder.sv
// IO-bus responder backed by a word-organised memory. Each beat takes a
// programmable number of wait states, completes with a one-cycle io_ready
// pulse and is always followed by at least one idle (GAP) cycle so the
// initiator sees a fresh rising edge per beat. Byte/half/word accesses and
// word-only incrementing bursts are supported; bad beats complete with io_err.
module io_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic      clk,
  input logic      rst,
  io_sram_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_TOP  = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        both_q;
  logic        burst_q;
  logic [2:0]  beats_q;
  logic [3:0]  wait_q;

  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic [7:0]  cnt_q;

  // Write commit is staged one cycle so reset can cancel it cleanly.
  logic             we_q;
  logic [IDX_W-1:0] widx_q;
  logic [3:0]       wmask_q;
  logic [31:0]      wlane_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             req;
  logic             more;
  logic             accept;
  logic             fire;
  logic [31:0]      b_addr;
  logic [31:0]      b_wdata;
  logic [1:0]       b_size;
  logic             b_wr;
  logic             b_both;
  logic             b_burst;
  logic             b_err;
  logic [IDX_W-1:0] b_idx;

  // Beat is errored on range, alignment, read+write collision, or a
  // burst that is not word-sized.
  function automatic logic beat_err(input logic [31:0] a, input logic [1:0] sz,
                                    input logic both, input logic bst);
    logic oor;
    logic mis;
    logic sub_word;
    oor      = (a < ADDR_BASE) || ({1'b0, a} >= ADDR_TOP);
    sub_word = (sz == 2'd1) || (sz == 2'd2);
    case (sz)
      2'd1:    mis = 1'b0;
      2'd2:    mis = a[0];
      default: mis = (a[1:0] != 2'b00);
    endcase
    return oor || mis || both || (bst && sub_word);
  endfunction

  // Byte lanes touched by a write of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd1:    return 4'b0001 << a;
      2'd2:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-aligned write data replicated into every lane it could occupy.
  function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] sz);
    case (sz)
      2'd1:    return {4{wd[7:0]}};
      2'd2:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Decode request acceptance and the attributes of the beat about to respond.
  always_comb begin
    req    = bus.io_read | bus.io_write;
    more   = burst_q && (beats_q != 3'd0);
    accept = req && ((state == IDLE) || ((state == GAP) && !more));
    if (state == WAIT) begin
      b_addr  = addr_q;
      b_wdata = wdata_q;
      b_size  = size_q;
      b_wr    = wr_q;
      b_both  = both_q;
      b_burst = burst_q;
    end else begin
      b_addr  = bus.io_addr;
      b_wdata = bus.io_wdata;
      b_size  = bus.io_byte_size;
      b_wr    = bus.io_write;
      b_both  = bus.io_read & bus.io_write;
      b_burst = bus.burst;
    end
    fire  = ((state == WAIT) && (wait_q == 4'd1)) || (accept && NO_WAIT);
    b_err = beat_err(b_addr, b_size, b_both, b_burst);
    b_idx = IDX_W'((b_addr - ADDR_BASE) >> 2);
  end

  // Control FSM with registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      burst_q <= 1'b0;
      beats_q <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      case (state)
        WAIT: wait_q <= wait_q - 4'd1;
        RESP: state <= GAP;
        GAP: begin
          if (!req) begin
            state <= IDLE;
          end else if (more) begin
            addr_q  <= addr_q + 32'd4;
            beats_q <= beats_q - 3'd1;
            wait_q  <= 4'd1;
            state   <= WAIT;
          end
        end
        default: ;
      endcase
      if (accept) begin
        addr_q  <= bus.io_addr;
        wdata_q <= bus.io_wdata;
        size_q  <= bus.io_byte_size;
        wr_q    <= bus.io_write;
        both_q  <= bus.io_read & bus.io_write;
        burst_q <= bus.burst;
        beats_q <= bus.burst_size;
        wait_q  <= WAIT_INIT;
        state   <= WAIT;
      end
      if (fire) begin
        state   <= RESP;
        ready_q <= 1'b1;
        err_q   <= b_err;
        we_q    <= b_wr & ~b_err;
        if (b_err) cnt_q <= sat_inc(cnt_q);
        if (!b_wr) rdata_q <= b_err ? 32'd0 : mem[b_idx];
      end
    end
  end

  // Stage write lanes at response time and commit them on the next edge.
  always_ff @(posedge clk) begin
    if (fire) begin
      widx_q  <= b_idx;
      wmask_q <= lane_mask(b_addr[1:0], b_size);
      wlane_q <= lane_data(b_wdata, b_size);
    end
    if (we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[widx_q][8*i +: 8] <= wlane_q[8*i +: 8];
      end
    end
  end

  assign bus.io_rdata  = rdata_q;
  assign bus.io_ready  = ready_q;
  assign bus.io_err    = err_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_io_sram_responder.sv
// Randomised bench for io_sram_responder with a byte-addressed reference model.
module tb_io_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          WS   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  io_sram_if bus();

  io_sram_responder #(
    .ADDR_BASE(BASE),
    .DEPTH_WORDS(1024),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  m_mem [4096];
  int          m_cnt   = 0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz, input logic both);
    if (a < BASE || a >= BASE + 32'd4096) return 1'b1;
    if ((a & 32'(m_nbytes(sz) - 1)) != 0) return 1'b1;
    return both;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    for (int i = 0; i < m_nbytes(sz); i++) m_mem[int'(a - BASE) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int o;
    o = int'((a - BASE) & 32'hFFFF_FFFC);
    return {m_mem[o+3], m_mem[o+2], m_mem[o+1], m_mem[o]};
  endfunction

  task automatic m_bump();
    if (m_cnt < 255) m_cnt++;
  endtask

  // Waits for the next io_ready pulse; lat = negedges waited, -1 on timeout.
  task automatic wait_ready(input bit scr, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.io_ready === 1'b1) begin
        lat = k;
        break;
      end
      if (scr) begin
        bus.io_addr      = $urandom;
        bus.io_wdata     = $urandom;
        bus.io_byte_size = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.io_ready !== 1'b0) pulses++;
    end
    chk(tag, pulses, 0);
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz,
                       output logic [31:0] rdat);
    int         lat;
    logic       er;
    logic       e;
    logic [7:0] cnt;
    @(negedge clk);
    bus.io_read      = rd;
    bus.io_write     = wr;
    bus.io_addr      = a;
    bus.io_wdata     = wd;
    bus.io_byte_size = sz;
    bus.burst        = 1'b0;
    bus.burst_size   = 3'($urandom_range(0, 7));
    wait_ready(1'b1, lat);
    rdat = bus.io_rdata;
    er   = bus.io_err;
    cnt  = bus.err_count;
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    e = m_err(a, sz, rd & wr);
    if (e) m_bump();
    else if (wr) m_write(a, wd, sz);
    if (!wr) m_rdata = e ? 32'd0 : m_word(a);
    chk("latency", lat, 1 + WS);
    chk("err_flag", er, e);
    chk("rdata", rdat, m_rdata);
    chk("err_count", cnt, m_cnt);
    @(negedge clk);
    chk("single_pulse", bus.io_ready, 1'b0);
  endtask

  // Burst read; drop_after=0 runs all beats, otherwise drops after that beat.
  task automatic burst_rd(input logic [31:0] a, input logic [2:0] bs,
                          input logic [1:0] sz, input int drop_after);
    int          lat;
    logic        e;
    logic [31:0] ba;
    @(negedge clk);
    bus.io_read      = 1'b1;
    bus.io_write     = 1'b0;
    bus.io_addr      = a;
    bus.io_byte_size = sz;
    bus.burst        = 1'b1;
    bus.burst_size   = bs;
    for (int b = 0; b <= int'(bs); b++) begin
      wait_ready(1'b0, lat);
      ba = a + 32'(4 * b);
      e  = m_err(ba, sz, 1'b0) || (sz == 2'd1) || (sz == 2'd2);
      if (e) m_bump();
      m_rdata = e ? 32'd0 : m_word(ba);
      chk((b == 0) ? "burst_first_lat" : "burst_beat_lat", lat, (b == 0) ? 1 + WS : 3);
      chk("burst_err", bus.io_err, e);
      chk("burst_data", bus.io_rdata, m_rdata);
      chk("burst_err_count", bus.err_count, m_cnt);
      bus.io_addr = $urandom;
      if (b + 1 == drop_after) break;
    end
    bus.io_read = 1'b0;
    bus.burst   = 1'b0;
    quiet("burst_quiet", 8);
  endtask

  initial begin : main
    logic [31:0] rdat;
    logic [31:0] old;
    int          lat;
    int          pulses;
    int          r;
    logic [31:0] a;
    logic [31:0] oor_list [5];

    bus.io_addr      = '0;
    bus.io_read      = 1'b0;
    bus.io_write     = 1'b0;
    bus.io_wdata     = '0;
    bus.io_byte_size = '0;
    bus.burst        = 1'b0;
    bus.burst_size   = '0;
    oor_list[0] = 32'h7FFF_FFFC;
    oor_list[1] = 32'h8000_1000;
    oor_list[2] = 32'h8000_1004;
    oor_list[3] = 32'h0000_0000;
    oor_list[4] = 32'hFFFF_FFFC;

    repeat (3) @(negedge clk);
    chk("reset_ready", bus.io_ready, 1'b0);
    chk("reset_err", bus.io_err, 1'b0);
    chk("reset_rdata", bus.io_rdata, 32'd0);
    chk("reset_err_count", bus.err_count, 8'd0);
    rst = 1'b1;

    // Preload the first 64 words through the bus.
    for (int i = 0; i < 64; i++) do_op(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 2'd0, rdat);

    do_op(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 2'd0, rdat);
    do_op(1'b1, 1'b0, BASE + 32'h10, 32'h0, 2'd0, rdat);
    chk("read_deadbeef", rdat, 32'hDEAD_BEEF);

    do_op(1'b0, 1'b1, BASE + 32'h10, 32'h1122_3344, 2'd3, rdat);
    do_op(1'b0, 1'b1, BASE + 32'h13, 32'h0000_00AB, 2'd1, rdat);
    do_op(1'b0, 1'b1, BASE + 32'h10, 32'h0000_CDEF, 2'd2, rdat);
    do_op(1'b1, 1'b0, BASE + 32'h10, 32'h0, 2'd0, rdat);
    chk("lane_merge", rdat, 32'hAB22_CDEF);

    // Line refill: read held, address stepped after each pulse.
    @(negedge clk);
    bus.io_read      = 1'b1;
    bus.io_addr      = BASE;
    bus.io_byte_size = 2'd0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(1'b0, lat);
      chk("refill_lat", lat, (k == 0) ? 1 + WS : 2 + WS);
      chk("refill_data", bus.io_rdata, m_word(BASE + 32'(4 * k)));
      chk("refill_err", bus.io_err, 1'b0);
      m_rdata = m_word(BASE + 32'(4 * k));
      if (k == 3) bus.io_read = 1'b0;
      else bus.io_addr = BASE + 32'(4 * (k + 1));
    end
    quiet("refill_quiet", 6);

    burst_rd(BASE + 32'h20, 3'd7, 2'd0, 0);
    burst_rd(BASE + 32'h20, 3'd7, 2'd0, 3);
    burst_rd(BASE + 32'h40, 3'd1, 2'd1, 0);
    burst_rd(BASE + 32'h0FF8, 3'd3, 2'd0, 0);
    do_op(1'b1, 1'b1, BASE + 32'h24, 32'h5555_AAAA, 2'd0, rdat);
    do_op(1'b1, 1'b0, BASE + 32'h24, 32'h0, 2'd0, rdat);

    // Reset in the middle of a write's wait states.
    old = m_word(BASE + 32'h4);
    @(negedge clk);
    bus.io_write     = 1'b1;
    bus.io_addr      = BASE + 32'h4;
    bus.io_wdata     = ~old;
    bus.io_byte_size = 2'd0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", bus.io_ready, 1'b0);
    chk("rst_err", bus.io_err, 1'b0);
    chk("rst_rdata", bus.io_rdata, 32'd0);
    chk("rst_err_count", bus.err_count, 8'd0);
    bus.io_write = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.io_ready !== 1'b0) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);
    rst = 1'b1;
    m_cnt   = 0;
    m_rdata = '0;
    quiet("rst_release_quiet", 2);
    do_op(1'b1, 1'b0, BASE + 32'h4, 32'h0, 2'd0, rdat);
    chk("rst_no_commit", rdat, old);

    do_op(1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 2'd0, rdat);
    chk("oor_rdata", rdat, 32'd0);
    do_op(1'b1, 1'b0, 32'h8000_0001, 32'h0, 2'd2, rdat);
    chk("misalign_rdata", rdat, 32'd0);
    chk("err_count_two", bus.err_count, 8'd2);
    old = m_word(BASE);
    do_op(1'b0, 1'b1, 32'h8000_1000, ~old, 2'd0, rdat);
    do_op(1'b1, 1'b0, BASE, 32'h0, 2'd0, rdat);
    chk("oor_write_dropped", rdat, old);

    // Random single accesses.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = oor_list[$urandom_range(0, 4)];
      else a = BASE + 32'($urandom_range(0, 255));
      do_op((r <= 4) || (r == 9), (r >= 5), a, $urandom, 2'($urandom_range(0, 3)), rdat);
    end

    // Random bursts.
    for (int n = 0; n < 6; n++) begin
      burst_rd(BASE + 32'(4 * $urandom_range(0, 48)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0, $urandom_range(0, 3));
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) do_op(1'b1, 1'b0, 32'h0000_0000, 32'h0, 2'd0, rdat);
    chk("err_count_sat", bus.err_count, 8'd255);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
